mem_access: RTL and testbench

- Memory-access stage directly downstream of the execute stage.
- Consumes the ALU result: address for load/store, passthrough value for everything else.
- Drives a single-outstanding data-memory request/ack bus; aligns and sign/zero-extends load data; generates store byte strobes.
- Reports misaligned and access-fault exceptions; presents one registered result per instruction to writeback via valid/ready.

---
 rtl/mem_access_pkg.sv | 19 +
 rtl/mem_access_lsu_align.sv | 31 +++
 rtl/mem_access.sv | 118 +++++++++++
 tb/tb_mem_access.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size encodings, exception codes, FSM states and alignment helper.
package mem_access_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [3:0] EXC_LD_MIS = 4'd4;
  localparam logic [3:0] EXC_LD_FLT = 4'd5;
  localparam logic [3:0] EXC_ST_MIS = 4'd6;
  localparam logic [3:0] EXC_ST_FLT = 4'd7;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3[1:0] == F3_H[1:0] && a[0]) || (f3[1:0] == F3_W[1:0] && a != 2'b00);
  endfunction
endpackage

// File: rtl/mem_access_lsu_align.sv
// lsu_align: store lane replication/strobes and load byte/half extraction with extension.
module lsu_align
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] load_data
);
  logic [XLEN-1:0] sh;
  logic [7:0]      b;
  logic [15:0]     h;
  always_comb begin
    sh = rdata >> {addr_lo, 3'b000};
    b = sh[7:0];
    h = sh[15:0];
    wdata = funct3[1:0] == F3_B[1:0] ? {(XLEN/8){store_data[7:0]}}
          : funct3[1:0] == F3_H[1:0] ? {(XLEN/16){store_data[15:0]}} : store_data;
    wstrb = funct3[1:0] == F3_B[1:0] ? 4'b0001 << addr_lo
          : funct3[1:0] == F3_H[1:0] ? 4'b0011 << addr_lo : 4'b1111;
    load_data = funct3 == F3_B  ? {{(XLEN-8){b[7]}}, b}
              : funct3 == F3_BU ? {{(XLEN-8){1'b0}}, b}
              : funct3 == F3_H  ? {{(XLEN-16){h[15]}}, h}
              : funct3 == F3_HU ? {{(XLEN-16){1'b0}}, h} : sh;
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage with single-outstanding data bus, alignment, timeout and exceptions.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst,
  input  logic            E_valid_i,
  output logic            E_ready_o,
  input  logic [XLEN-1:0] E_valE_i,
  input  logic [XLEN-1:0] E_rs2_data_i,
  input  logic            E_load_i,
  input  logic            E_store_i,
  input  logic [2:0]      E_funct3_i,
  input  logic            flush_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [3:0]      dmem_wstrb_o,
  input  logic            dmem_ack_i,
  input  logic            dmem_err_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            M_valid_o,
  input  logic            M_ready_i,
  output logic [XLEN-1:0] M_valM_o,
  output logic            M_excp_o,
  output logic [3:0]      M_excp_code_o,
  output logic [XLEN-1:0] M_badaddr_o
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] addr_q, data_q, valm_q, bad_q, wdata, load_data;
  logic [2:0]      f3_q;
  logic            load_q, store_q, excp_q;
  logic [3:0]      code_q, wstrb;
  logic            req, tmo, bus_done, fault, keep;
  lsu_align #(.XLEN(XLEN)) u_align (
    .addr_lo(addr_q[1:0]), .funct3(f3_q), .store_data(data_q), .rdata(dmem_rdata_i),
    .wdata(wdata), .wstrb(wstrb), .load_data(load_data)
  );
  always_comb begin
    req = state == ST_REQ || state == ST_DRAIN;
    tmo = TIMEOUT_CYCLES != 0 && cnt == TLAST && !dmem_ack_i;
    bus_done = dmem_ack_i || tmo;
    fault = !dmem_ack_i || dmem_err_i;
    keep = state == ST_REQ && !flush_i;
  end
  assign E_ready_o     = state == ST_IDLE;
  assign dmem_req_o    = req;
  assign dmem_we_o     = req && store_q;
  assign dmem_addr_o   = req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign dmem_wdata_o  = req ? wdata : '0;
  assign dmem_wstrb_o  = req ? wstrb : 4'b0000;
  assign M_valid_o     = state == ST_DONE;
  assign M_valM_o      = valm_q;
  assign M_excp_o      = excp_q;
  assign M_excp_code_o = code_q;
  assign M_badaddr_o   = bad_q;
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      addr_q <= '0;
      data_q <= '0;
      f3_q <= '0;
      load_q <= 1'b0;
      store_q <= 1'b0;
      valm_q <= '0;
      excp_q <= 1'b0;
      code_q <= '0;
      bad_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (E_valid_i && !flush_i) begin
          addr_q <= E_valE_i;
          data_q <= E_rs2_data_i;
          f3_q <= E_funct3_i;
          load_q <= E_load_i;
          store_q <= E_store_i && !E_load_i;
          cnt <= '0;
          if (!(E_load_i || E_store_i)) begin
            valm_q <= E_valE_i;
            excp_q <= 1'b0;
            code_q <= '0;
            bad_q <= '0;
            state <= ST_DONE;
          end else if (misaligned(E_funct3_i, E_valE_i[1:0])) begin
            valm_q <= '0;
            excp_q <= 1'b1;
            code_q <= E_load_i ? EXC_LD_MIS : EXC_ST_MIS;
            bad_q <= E_valE_i;
            state <= ST_DONE;
          end else begin
            state <= ST_REQ;
          end
        end
        ST_REQ, ST_DRAIN: if (bus_done) begin
          state <= keep ? ST_DONE : ST_IDLE;
          if (keep) begin
            valm_q <= (load_q && !fault) ? load_data : '0;
            excp_q <= fault;
            code_q <= fault ? (load_q ? EXC_LD_FLT : EXC_ST_FLT) : 4'd0;
            bad_q <= fault ? addr_q : '0;
          end
        end else begin
          cnt <= cnt + 1'b1;
          if (flush_i) state <= ST_DRAIN;
        end
        default: if (flush_i || M_ready_i) state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench with directed loads/stores, faults, timeout, flush and reset.
module tb_mem_access;
  import mem_access_pkg::*;
  typedef struct {logic [31:0] v; logic e; logic [3:0] c; logic [31:0] b;} res_t;
  typedef struct {logic [31:0] a; logic we; logic [31:0] d; logic [3:0] s;} bus_t;
  logic clk = 1'b0, rst = 1'b1;
  logic E_valid_i = 1'b0, E_ready_o, E_load_i = 1'b0, E_store_i = 1'b0, flush_i = 1'b0;
  logic [31:0] E_valE_i = '0, E_rs2_data_i = '0;
  logic [2:0] E_funct3_i = '0;
  logic dmem_req_o, dmem_we_o, dmem_ack_i = 1'b0, dmem_err_i = 1'b0;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i = '0;
  logic [3:0] dmem_wstrb_o, M_excp_code_o;
  logic M_valid_o, M_ready_i = 1'b1, M_excp_o;
  logic [31:0] M_valM_o, M_badaddr_o;
  res_t res_q[$];
  bus_t bus_q[$];
  res_t rx;
  bus_t bx;
  int checks = 0, errors = 0, ack_delay = 0, reqcyc = 0, req_cycles = 0, n0 = 0;
  logic prev_req = 1'b0, seen_valid = 1'b0;
  always #5 clk = ~clk;
  mem_access #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst(rst), .E_valid_i(E_valid_i), .E_ready_o(E_ready_o), .E_valE_i(E_valE_i),
    .E_rs2_data_i(E_rs2_data_i), .E_load_i(E_load_i), .E_store_i(E_store_i), .E_funct3_i(E_funct3_i),
    .flush_i(flush_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o), .dmem_ack_i(dmem_ack_i),
    .dmem_err_i(dmem_err_i), .dmem_rdata_i(dmem_rdata_i), .M_valid_o(M_valid_o), .M_ready_i(M_ready_i),
    .M_valM_o(M_valM_o), .M_excp_o(M_excp_o), .M_excp_code_o(M_excp_code_o), .M_badaddr_o(M_badaddr_o)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask
  task automatic step;
    @(negedge clk);
    #1;
  endtask
  // memory responder and bus-request scoreboard
  initial forever begin
    @(negedge clk);
    if (dmem_req_o === 1'b1) begin
      if (!prev_req) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr 0x%08h expected no request", dmem_addr_o);
        end else begin
          bx = bus_q.pop_front();
          chk("bus_addr", dmem_addr_o, bx.a);
          chk("bus_we", 32'(dmem_we_o), 32'(bx.we));
          if (bx.we) begin
            chk("bus_wdata", dmem_wdata_o, bx.d);
            chk("bus_wstrb", 32'(dmem_wstrb_o), 32'(bx.s));
          end
        end
      end
      reqcyc++;
      req_cycles++;
      dmem_ack_i = (reqcyc == ack_delay);
    end else begin
      reqcyc = 0;
      dmem_ack_i = 1'b0;
    end
    prev_req = dmem_req_o === 1'b1;
  end
  // writeback result scoreboard
  initial forever begin
    @(negedge clk);
    if (!rst && M_valid_o === 1'b1 && M_ready_i) begin
      if (res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got valM 0x%08h expected none", M_valM_o);
      end else begin
        rx = res_q.pop_front();
        chk("valM", M_valM_o, rx.v);
        chk("excp", 32'(M_excp_o), 32'(rx.e));
        chk("excp_code", 32'(M_excp_code_o), 32'(rx.c));
        chk("badaddr", M_badaddr_o, rx.b);
      end
    end
  end
  task automatic issue(input logic [31:0] v, input logic [31:0] d, input logic ld, input logic st, input logic [2:0] f3);
    int n = 0;
    while (!E_ready_o && n < 40) begin step; n++; end
    chk("issue_ready", 32'(E_ready_o), 32'd1);
    E_valid_i = 1'b1;
    E_valE_i = v;
    E_rs2_data_i = d;
    E_load_i = ld;
    E_store_i = st;
    E_funct3_i = f3;
    step;
    E_valid_i = 1'b0;
    E_load_i = 1'b0;
    E_store_i = 1'b0;
  endtask
  task automatic wait_idle;
    int n = 0;
    while (!E_ready_o && n < 40) begin step; n++; end
    chk("return_idle", 32'(E_ready_o), 32'd1);
  endtask
  task automatic mem_op(input logic [31:0] v, input logic [31:0] d, input logic ld, input logic st,
                        input logic [2:0] f3, input int dly, input logic [31:0] rd, input logic err,
                        input res_t r, input bus_t b, input logic has_bus);
    ack_delay = dly;
    dmem_rdata_i = rd;
    dmem_err_i = err;
    res_q.push_back(r);
    if (has_bus) bus_q.push_back(b);
    issue(v, d, ld, st, f3);
    wait_idle;
    dmem_err_i = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) step;
    chk("rst_ready", 32'(E_ready_o), 32'd1);
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_valid", 32'(M_valid_o), 32'd0);
    chk("rst_valM", M_valM_o, 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    rst = 1'b0;
    step;
    n0 = req_cycles;
    res_q.push_back('{32'h1234, 1'b0, 4'd0, 32'd0});
    issue(32'h1234, 32'd0, 1'b0, 1'b0, F3_W);
    chk("nonmem_latency", 32'(M_valid_o), 32'd1);
    wait_idle;
    chk("nonmem_noreq", 32'(req_cycles - n0), 32'd0);
    mem_op(32'h103, 0, 1, 0, F3_B, 2, 32'h80FF_FF00, 0, '{32'hFFFF_FF80, 0, 0, 0}, '{32'h100, 0, 0, 0}, 1);
    mem_op(32'h103, 0, 1, 0, F3_BU, 2, 32'h80FF_FF00, 0, '{32'h0000_0080, 0, 0, 0}, '{32'h100, 0, 0, 0}, 1);
    mem_op(32'h202, 32'hABCD, 0, 1, F3_H, 1, 0, 0, '{0, 0, 0, 0}, '{32'h200, 1, 32'hABCD_ABCD, 4'b1100}, 1);
    mem_op(32'h106, 0, 1, 0, F3_H, 1, 32'h8001_7FFF, 0, '{32'hFFFF_8001, 0, 0, 0}, '{32'h104, 0, 0, 0}, 1);
    mem_op(32'h106, 0, 1, 0, F3_HU, 1, 32'h8001_7FFF, 0, '{32'h0000_8001, 0, 0, 0}, '{32'h104, 0, 0, 0}, 1);
    mem_op(32'h10, 0, 1, 0, F3_W, 3, 32'hDEAD_BEEF, 0, '{32'hDEAD_BEEF, 0, 0, 0}, '{32'h10, 0, 0, 0}, 1);
    mem_op(32'h7, 32'h1234_5678, 0, 1, F3_B, 1, 0, 0, '{0, 0, 0, 0}, '{32'h4, 1, 32'h7878_7878, 4'b1000}, 1);
    n0 = req_cycles;
    mem_op(32'h101, 0, 1, 0, F3_W, 1, 0, 0, '{0, 1, 4'd4, 32'h101}, '{0, 0, 0, 0}, 0);
    mem_op(32'h102, 32'h55, 0, 1, F3_W, 1, 0, 0, '{0, 1, 4'd6, 32'h102}, '{0, 0, 0, 0}, 0);
    chk("misaligned_noreq", 32'(req_cycles - n0), 32'd0);
    n0 = req_cycles;
    mem_op(32'h300, 0, 1, 0, F3_W, 0, 0, 0, '{0, 1, 4'd5, 32'h300}, '{32'h300, 0, 0, 0}, 1);
    chk("timeout_ld_cycles", 32'(req_cycles - n0), 32'd4);
    n0 = req_cycles;
    mem_op(32'h304, 32'h11, 0, 1, F3_W, 0, 0, 0, '{0, 1, 4'd7, 32'h304}, '{32'h304, 1, 32'h11, 4'b1111}, 1);
    chk("timeout_st_cycles", 32'(req_cycles - n0), 32'd4);
    mem_op(32'h400, 0, 1, 0, F3_B, 1, 32'hFFFF_FFFF, 1, '{0, 1, 4'd5, 32'h400}, '{32'h400, 0, 0, 0}, 1);
    mem_op(32'h401, 32'h5A, 0, 1, F3_B, 1, 0, 1, '{0, 1, 4'd7, 32'h401}, '{32'h400, 1, 32'h5A5A_5A5A, 4'b0010}, 1);
    // reset while a request is outstanding; result regs still hold the store-fault
    ack_delay = 0;
    bus_q.push_back('{32'h600, 0, 0, 0});
    issue(32'h600, 0, 1'b1, 1'b0, F3_W);
    chk("req_before_rst", 32'(dmem_req_o), 32'd1);
    rst = 1'b1;
    step;
    chk("rst_req_drop", 32'(dmem_req_o), 32'd0);
    chk("rst_req_ready", 32'(E_ready_o), 32'd1);
    chk("rst_req_valid", 32'(M_valid_o), 32'd0);
    chk("rst_req_excp", 32'(M_excp_o), 32'd0);
    chk("rst_req_code", 32'(M_excp_code_o), 32'd0);
    chk("rst_req_badaddr", M_badaddr_o, 32'd0);
    rst = 1'b0;
    step;
    M_ready_i = 1'b0;
    issue(32'h55, 0, 1'b0, 1'b0, F3_W);
    step;
    step;
    chk("done_hold_valid", 32'(M_valid_o), 32'd1);
    chk("done_hold_valM", M_valM_o, 32'h55);
    flush_i = 1'b1;
    step;
    flush_i = 1'b0;
    chk("done_flush_valid", 32'(M_valid_o), 32'd0);
    chk("done_flush_ready", 32'(E_ready_o), 32'd1);
    M_ready_i = 1'b1;
    ack_delay = 4;
    dmem_rdata_i = 32'hCAFE_F00D;
    bus_q.push_back('{32'h500, 0, 0, 0});
    n0 = req_cycles;
    issue(32'h500, 0, 1'b1, 1'b0, F3_W);
    flush_i = 1'b1;
    step;
    flush_i = 1'b0;
    for (int n = 0; n < 20 && !dmem_ack_i; n++) begin
      if (M_valid_o) seen_valid = 1'b1;
      step;
    end
    chk("drain_ack_seen", 32'(dmem_ack_i), 32'd1);
    step;
    chk("drain_ready", 32'(E_ready_o), 32'd1);
    chk("drain_req_drop", 32'(dmem_req_o), 32'd0);
    chk("drain_no_valid", 32'(seen_valid | M_valid_o), 32'd0);
    chk("drain_req_cycles", 32'(req_cycles - n0), 32'd4);
    step;
    chk("res_queue_empty", 32'(res_q.size()), 32'd0);
    chk("bus_queue_empty", 32'(bus_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
